spi_xfer_arbiter: RTL and testbench

//  Round-robin arbiter and transfer sequencer sharing one SPI master (SPI_regs core) between NREQ requesters.

---
 rtl/spi_xfer_arbiter.sv | 224 ++++++++++++++++++++++
 tb/tb_spi_xfer_arbiter.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_xfer_arbiter.sv
// spi_xfer_arbiter
//   Round-robin arbiter and transfer sequencer that shares one SPI master core
//   between NREQ requesters. It grants one requester, latches that requester's
//   config and MOSI word, and pulses the core start for one cycle. It then
//   follows core busy until the transfer ends, captures the MISO word and
//   pulses done to the granted requester.
//
//   Optional feature macro: SPI_ARB_TIMEOUT_EN
//     When defined, a watchdog aborts a wait state after TIMEOUT_CYC cycles.
//     The aborted transfer completes with rdata_o = 0 and a one-cycle err_o
//     pulse alongside done_o.
//     When undefined, the FSM waits on the core indefinitely and err_o is 0.
//
//   Ports
//     GCLK, NRST      clock, asynchronous active-low reset
//     req_i           per-requester level request
//     cfg_i           per-requester {mode,speed,word_len,IFG,CS_SCK,SCK_CS}, 30b each
//     wdata_i         per-requester MOSI word, 32b each
//     gnt_o           one-hot grant, held from LOAD through DONE
//     done_o          one-cycle completion pulse to the granted requester
//     rdata_o         MISO word captured at completion (0 on timeout)
//     err_o           one-cycle timeout pulse, coincident with done_o
//     spi_*_o / *_o   control and config to the SPI core
//     spi_busy_i      core busy
//     miso_data_i     core MISO word
//
//   state        | meaning
//   -------------+---------------------------------------------------------
//   ST_IDLE      | no transfer; pick next requester after the RR pointer
//   ST_LOAD      | latch winner's cfg/wdata, or abandon if its request dropped
//   ST_START     | one-cycle start pulse to the core
//   ST_WAIT_BUSY | wait for the core to raise busy
//   ST_WAIT_DONE | wait for the core to drop busy
//   ST_DONE      | done pulse to the winner, grant released on exit
module spi_xfer_arbiter #(
    parameter int NREQ        = 2,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic                 GCLK,
    input  logic                 NRST,
    input  logic [NREQ-1:0]      req_i,
    input  logic [NREQ*30-1:0]   cfg_i,
    input  logic [NREQ*32-1:0]   wdata_i,
    output logic [NREQ-1:0]      gnt_o,
    output logic [NREQ-1:0]      done_o,
    output logic [31:0]          rdata_o,
    output logic                 err_o,
    output logic                 spi_start_o,
    input  logic                 spi_busy_i,
    output logic [1:0]           spi_mode_o,
    output logic [1:0]           sck_speed_o,
    output logic [1:0]           word_len_o,
    output logic [7:0]           ifg_o,
    output logic [7:0]           cs_sck_o,
    output logic [7:0]           sck_cs_o,
    output logic [31:0]          mosi_data_o,
    input  logic [31:0]          miso_data_i
);

    localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    if (NREQ < 2 || NREQ > 8 || TIMEOUT_CYC < 2) begin : g_bad_param
        $error("spi_xfer_arbiter: NREQ must be 2..8 and TIMEOUT_CYC at least 2");
    end

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_START,
        ST_WAIT_BUSY,
        ST_WAIT_DONE,
        ST_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [NREQ-1:0]  gnt_q, gnt_d;
    logic [29:0]      cfg_q, cfg_d;
    logic [31:0]      mosi_q, mosi_d;
    logic [31:0]      rdata_q, rdata_d;
    logic [IDX_W-1:0] win_idx;
    logic             win_found;
    logic             tmo_hit;

`ifdef SPI_ARB_TIMEOUT_EN
    localparam int TMO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    // Down-counter reloaded on entry to each wait state; terminal count 0
    // means TIMEOUT_CYC cycles have been spent in that state.
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic             err_q, err_d;

    assign tmo_hit = (tmo_q == '0);

    always_comb begin
        tmo_d = tmo_q;
        err_d = 1'b0;
        if (state_q == ST_START || (state_q == ST_WAIT_BUSY && spi_busy_i)) begin
            tmo_d = TMO_W'(TIMEOUT_CYC - 1);
        end else if ((state_q == ST_WAIT_BUSY || state_q == ST_WAIT_DONE) && !tmo_hit) begin
            tmo_d = tmo_q - 1'b1;
        end
        if (tmo_hit && ((state_q == ST_WAIT_BUSY && !spi_busy_i) ||
                        (state_q == ST_WAIT_DONE &&  spi_busy_i))) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge GCLK or negedge NRST) begin
        if (!NRST) begin
            tmo_q <= '0;
            err_q <= 1'b0;
        end else begin
            tmo_q <= tmo_d;
            err_q <= err_d;
        end
    end

    assign err_o = (state_q == ST_DONE) && err_q;
`else
    assign tmo_hit = 1'b0;
    assign err_o   = 1'b0;
`endif

    // First requester strictly after the pointer, wrapping; the pointer
    // itself is checked last so a lone repeat requester still wins.
    always_comb begin
        win_found = 1'b0;
        win_idx   = ptr_q;
        for (int i = 1; i <= NREQ; i++) begin
            if (!win_found && req_i[(int'(ptr_q) + i) % NREQ]) begin
                win_found = 1'b1;
                win_idx   = IDX_W'((int'(ptr_q) + i) % NREQ);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        gnt_d   = gnt_q;
        cfg_d   = cfg_q;
        mosi_d  = mosi_q;
        rdata_d = rdata_q;
        case (state_q)
            ST_IDLE: begin
                if (win_found) begin
                    ptr_d          = win_idx;
                    gnt_d          = '0;
                    gnt_d[win_idx] = 1'b1;
                    state_d        = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (req_i[ptr_q]) begin
                    cfg_d   = cfg_i[int'(ptr_q)*30 +: 30];
                    mosi_d  = wdata_i[int'(ptr_q)*32 +: 32];
                    state_d = ST_START;
                end else begin
                    gnt_d   = '0;
                    state_d = ST_IDLE;
                end
            end
            ST_START: state_d = ST_WAIT_BUSY;
            ST_WAIT_BUSY: begin
                if (spi_busy_i) begin
                    state_d = ST_WAIT_DONE;
                end else if (tmo_hit) begin
                    rdata_d = '0;
                    state_d = ST_DONE;
                end
            end
            ST_WAIT_DONE: begin
                // Capture on the way into DONE so rdata_o is valid with done_o.
                if (!spi_busy_i) begin
                    rdata_d = miso_data_i;
                    state_d = ST_DONE;
                end else if (tmo_hit) begin
                    rdata_d = '0;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                gnt_d   = '0;
                state_d = ST_IDLE;
            end
            default: begin
                gnt_d   = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge GCLK or negedge NRST) begin
        if (!NRST) begin
            state_q <= ST_IDLE;
            ptr_q   <= IDX_W'(NREQ - 1);
            gnt_q   <= '0;
            cfg_q   <= '0;
            mosi_q  <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gnt_q   <= gnt_d;
            cfg_q   <= cfg_d;
            mosi_q  <= mosi_d;
            rdata_q <= rdata_d;
        end
    end

    assign gnt_o       = gnt_q;
    assign done_o      = (state_q == ST_DONE) ? gnt_q : '0;
    assign rdata_o     = rdata_q;
    assign spi_start_o = (state_q == ST_START);
    assign spi_mode_o  = cfg_q[29:28];
    assign sck_speed_o = cfg_q[27:26];
    assign word_len_o  = cfg_q[25:24];
    assign ifg_o       = cfg_q[23:16];
    assign cs_sck_o    = cfg_q[15:8];
    assign sck_cs_o    = cfg_q[7:0];
    assign mosi_data_o = mosi_q;

endmodule

// File: tb/tb_spi_xfer_arbiter.sv
// Bench for spi_xfer_arbiter: behavioural SPI core model plus a scoreboard of
// expected completions (grant, MISO word, error flag) consumed on each done_o.
module tb_spi_xfer_arbiter;
    localparam int NREQ = 2;
    localparam int TMO  = 16;

    logic               GCLK = 1'b0;
    logic               NRST;
    logic [NREQ-1:0]    req_i;
    logic [NREQ*30-1:0] cfg_i;
    logic [NREQ*32-1:0] wdata_i;
    logic [NREQ-1:0]    gnt_o, done_o;
    logic [31:0]        rdata_o, mosi_data_o, miso_data_i;
    logic               err_o, spi_start_o, spi_busy_i;
    logic [1:0]         spi_mode_o, sck_speed_o, word_len_o;
    logic [7:0]         ifg_o, cs_sck_o, sck_cs_o;

    spi_xfer_arbiter #(.NREQ(NREQ), .TIMEOUT_CYC(TMO)) dut (
        .GCLK(GCLK), .NRST(NRST), .req_i(req_i), .cfg_i(cfg_i), .wdata_i(wdata_i),
        .gnt_o(gnt_o), .done_o(done_o), .rdata_o(rdata_o), .err_o(err_o),
        .spi_start_o(spi_start_o), .spi_busy_i(spi_busy_i),
        .spi_mode_o(spi_mode_o), .sck_speed_o(sck_speed_o), .word_len_o(word_len_o),
        .ifg_o(ifg_o), .cs_sck_o(cs_sck_o), .sck_cs_o(sck_cs_o),
        .mosi_data_o(mosi_data_o), .miso_data_i(miso_data_i)
    );

    always #5 GCLK = ~GCLK;

    logic [99:0] all_outs;
    logic [61:0] cur_cfg;
    assign all_outs = {gnt_o, done_o, rdata_o, err_o, spi_start_o, spi_mode_o, sck_speed_o,
                       word_len_o, ifg_o, cs_sck_o, sck_cs_o, mosi_data_o};
    assign cur_cfg  = {spi_mode_o, sck_speed_o, word_len_o, ifg_o, cs_sck_o, sck_cs_o, mosi_data_o};

    typedef struct {
        logic [NREQ-1:0] gnt;
        logic [31:0]     rdata;
        logic            err;
    } exp_t;

    exp_t        sb_q[$];
    exp_t        mon_e;
    int          n_checks  = 0;
    int          n_errors  = 0;
    int          start_cnt = 0;
    int          busy_len  = 4;
    bit          core_stuck = 1'b0;
    logic [61:0] snap = '0;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] miso_of(input logic [31:0] w);
        return {16'h3C3C, w[15:0]};
    endfunction

    task automatic push_exp(input int k, input logic [31:0] rd, input logic er);
        exp_t e;
        e.gnt    = '0;
        e.gnt[k] = 1'b1;
        e.rdata  = rd;
        e.err    = er;
        sb_q.push_back(e);
    endtask

    task automatic set_req(input int k, input logic [29:0] c, input logic [31:0] w);
        cfg_i[k*30 +: 30]   = c;
        wdata_i[k*32 +: 32] = w;
    endtask

    task automatic wait_done(input int k, input int budget, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(posedge GCLK); #1;
            if (done_o[k]) begin
                seen = 1'b1;
                break;
            end
        end
    endtask

    task automatic do_reset();
        #2 NRST = 1'b0;
        req_i = '0;
        repeat (2) @(posedge GCLK);
        #1 NRST = 1'b1;
        sb_q.delete();
    endtask

    // SPI core model: busy rises the cycle after start, lasts busy_len cycles,
    // and the MISO word is presented as busy falls. Abandons on reset.
    initial begin : core_model
        logic [31:0] w;
        spi_busy_i  = 1'b0;
        miso_data_i = '0;
        forever begin
            @(negedge GCLK);
            if (NRST && spi_start_o && !core_stuck) begin
                w = mosi_data_o;
                @(posedge GCLK); #1;
                if (NRST) spi_busy_i = 1'b1;
                for (int i = 1; i < busy_len && NRST; i++) begin
                    @(posedge GCLK); #1;
                end
                miso_data_i = NRST ? miso_of(w) : 32'h0;
                spi_busy_i  = 1'b0;
            end
        end
    end

    always @(negedge GCLK) begin
        if (NRST) begin
            if (spi_start_o) begin
                start_cnt++;
                chk("start_while_busy", 128'(spi_busy_i), 128'(1'b0));
                snap = cur_cfg;
            end
            if (done_o != '0) begin
                chk("cfg_stable", 128'(cur_cfg), 128'(snap));
                if (sb_q.size() == 0) begin
                    chk("unexpected_done", 128'(done_o), 128'(0));
                end else begin
                    mon_e = sb_q.pop_front();
                    chk("done_gnt", 128'(done_o), 128'(mon_e.gnt));
                    chk("rdata", 128'(rdata_o), 128'(mon_e.rdata));
                    chk("err", 128'(err_o), 128'(mon_e.err));
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        bit seen;
        int s0;
        int cyc;
        bit any_done, any_err;
        NRST = 1'b0; req_i = '0; cfg_i = '0; wdata_i = '0;
        repeat (3) @(posedge GCLK); #1;
        chk("reset_outs", 128'(all_outs), 128'(0));
        NRST = 1'b1;

        // 1: single transfer from requester 0
        set_req(0, {2'd1, 2'd0, 2'd2, 8'h03, 8'h02, 8'h01}, 32'hA5A5_0001);
        busy_len = 4;
        push_exp(0, 32'h3C3C_0001, 1'b0);
        s0 = start_cnt;
        @(posedge GCLK); #1 req_i = 2'b01;
        @(posedge GCLK); #1;
        chk("t1_gnt", 128'(gnt_o), 128'(2'b01));
        @(posedge GCLK); #1;
        chk("t1_start", 128'(spi_start_o), 128'(1'b1));
        chk("t1_mosi", 128'(mosi_data_o), 128'(32'hA5A5_0001));
        chk("t1_mode", 128'(spi_mode_o), 128'(2'd1));
        chk("t1_wlen", 128'(word_len_o), 128'(2'd2));
        wait_done(0, 50, seen);
        chk("t1_done_seen", 128'(seen), 128'(1'b1));
        req_i = '0;
        @(posedge GCLK); #1;
        chk("t1_gnt_clear", 128'(gnt_o), 128'(0));
        chk("t1_rdata_hold", 128'(rdata_o), 128'(32'h3C3C_0001));
        chk("t1_starts", 128'(start_cnt - s0), 128'(1));

        // 2: both requesting continuously -> 0,1,0,1
        do_reset();
        set_req(0, {2'd2, 2'd1, 2'd1, 8'h10, 8'h20, 8'h30}, 32'h1111_00AA);
        set_req(1, {2'd3, 2'd3, 2'd0, 8'h44, 8'h55, 8'h66}, 32'h2222_00BB);
        for (int i = 0; i < 4; i++) push_exp(i % 2, (i % 2 == 0) ? 32'h3C3C_00AA : 32'h3C3C_00BB, 1'b0);
        s0 = start_cnt;
        busy_len = 2;
        req_i = 2'b11;
        for (int i = 0; i < 4; i++) begin
            wait_done(i % 2, 60, seen);
            chk("t2_done_seen", 128'(seen), 128'(1'b1));
            busy_len = 3 + i;
        end
        req_i = '0;
        repeat (3) @(posedge GCLK); #1;
        chk("t2_starts", 128'(start_cnt - s0), 128'(4));
        chk("t2_sb_empty", 128'(sb_q.size()), 128'(0));

        // 3: request dropped during LOAD -> no start; next 11 goes to requester 1
        s0 = start_cnt;
        req_i = 2'b01;
        @(posedge GCLK); #1;
        chk("t3_gnt_load", 128'(gnt_o), 128'(2'b01));
        req_i = '0;
        @(posedge GCLK); #1;
        chk("t3_gnt_clear", 128'(gnt_o), 128'(0));
        repeat (3) @(posedge GCLK); #1;
        chk("t3_no_start", 128'(start_cnt - s0), 128'(0));
        push_exp(1, 32'h3C3C_00BB, 1'b0);
        req_i = 2'b11;
        wait_done(1, 60, seen);
        chk("t3_done_seen", 128'(seen), 128'(1'b1));
        req_i = '0;
        repeat (3) @(posedge GCLK); #1;

        // 4: reset during WAIT_DONE, then requester 1 completes
        busy_len = 30;
        req_i = 2'b01;
        for (int i = 0; i < 20; i++) begin
            @(posedge GCLK); #1;
            if (spi_busy_i) break;
        end
        chk("t4_busy_seen", 128'(spi_busy_i), 128'(1'b1));
        @(posedge GCLK); #3;
        NRST = 1'b0;
        #1;
        chk("t4_reset_outs", 128'(all_outs), 128'(0));
        req_i = '0;
        repeat (2) @(posedge GCLK);
        #1 NRST = 1'b1;
        sb_q.delete();
        busy_len = 3;
        push_exp(1, 32'h3C3C_00BB, 1'b0);
        req_i = 2'b10;
        wait_done(1, 60, seen);
        chk("t4_done_seen", 128'(seen), 128'(1'b1));
        req_i = '0;
        repeat (3) @(posedge GCLK); #1;

        // 5: core never raises busy
        core_stuck = 1'b1;
`ifdef SPI_ARB_TIMEOUT_EN
        push_exp(0, 32'h0, 1'b1);
`endif
        req_i = 2'b01;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge GCLK); #1;
            if (spi_start_o) begin
                seen = 1'b1;
                break;
            end
        end
        chk("t5_start_seen", 128'(seen), 128'(1'b1));
        @(posedge GCLK); #1;
        cyc = 0;
`ifdef SPI_ARB_TIMEOUT_EN
        for (int i = 0; i < 40; i++) begin
            @(posedge GCLK); #1;
            cyc++;
            if (done_o[0]) break;
        end
        chk("t5_tmo_cycles", 128'(cyc), 128'(TMO));
        chk("t5_err", 128'(err_o), 128'(1'b1));
        chk("t5_rdata_zero", 128'(rdata_o), 128'(0));
        req_i = '0;
        repeat (3) @(posedge GCLK); #1;
`else
        any_done = 1'b0;
        any_err  = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge GCLK); #1;
            any_done |= (done_o != '0);
            any_err  |= err_o;
        end
        chk("t5_no_done", 128'(any_done), 128'(1'b0));
        chk("t5_no_err", 128'(any_err), 128'(1'b0));
        chk("t5_gnt_held", 128'(gnt_o), 128'(2'b01));
        do_reset();
`endif
        core_stuck = 1'b0;
        repeat (3) @(posedge GCLK); #1;
        chk("end_sb_empty", 128'(sb_q.size()), 128'(0));

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
